// File: rtl/cpu_types_pkg.sv
// Shared CPU types: RAM handshake state, machine word and the memory
// arbiter's state encoding.
package cpu_types_pkg;

  localparam int ARB_ADDR_W = 32;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    FREE,
    BUSY,
    ACCESS,
    ERROR
  } ramstate_t;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_IGNT,
    ARB_DGNT
  } arb_state_t;

endpackage

// File: rtl/arb_perf_counter.sv
// Free-running 32-bit completion counter; one instance per requester,
// only built when ARB_PERF_EN is defined.
module arb_perf_counter
  import cpu_types_pkg::*;
(
  input  logic  CLK,
  input  logic  nRST,
  input  logic  inc_i,
  output word_t cnt_o
);

  word_t cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (inc_i) cnt_d = cnt_q + 32'd1;
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/mem_arbiter.sv
// Single-port RAM scheduler between icache and dcache with burst hold and
// icache starvation guard. Optional completion counters under ARB_PERF_EN.
module mem_arbiter
  import cpu_types_pkg::*;
#(
  parameter int BURST_LEN  = 2,
  parameter int STARVE_MAX = 8
) (
  input  logic                  CLK,
  input  logic                  nRST,
  input  logic                  iREN,
  input  word_t                 iaddr,
  output logic                  iwait,
  output word_t                 iload,
  input  logic                  dREN,
  input  logic                  dWEN,
  input  word_t                 daddr,
  input  word_t                 dstore,
  output logic                  dwait,
  output word_t                 dload,
  output logic                  ramREN,
  output logic                  ramWEN,
  output logic [ARB_ADDR_W-1:0] ramaddr,
  output word_t                 ramstore,
  input  word_t                 ramload,
  input  ramstate_t             ramstate,
  output word_t                 iaccess_cnt,
  output word_t                 daccess_cnt
);

  localparam int BW = $clog2(BURST_LEN + 1);
  localparam int SW = $clog2(STARVE_MAX + 1);

  arb_state_t      state_q, state_d;
  logic [BW-1:0]   beat_q, beat_d;
  logic [SW-1:0]   starve_q, starve_d;
  logic            dreq, icomp, dcomp;

  assign dreq  = dREN | dWEN;
  assign icomp = (state_q == ARB_IGNT) && (ramstate == ACCESS);
  assign dcomp = (state_q == ARB_DGNT) && (ramstate == ACCESS);

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q  <= ARB_IDLE;
      beat_q   <= '0;
      starve_q <= '0;
    end else begin
      state_q  <= state_d;
      beat_q   <= beat_d;
      starve_q <= starve_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    beat_d   = beat_q;
    ramREN   = 1'b0;
    ramWEN   = 1'b0;
    ramaddr  = '0;
    ramstore = '0;
    iload    = '0;
    dload    = '0;
    iwait    = 1'b1;
    dwait    = 1'b1;
    case (state_q)
      ARB_IDLE: begin
        // dcache wins unless icache has waited the full starvation budget
        if (dreq && !(iREN && starve_q == SW'(STARVE_MAX))) begin
          state_d = ARB_DGNT;
          beat_d  = '0;
        end else if (iREN) begin
          state_d = ARB_IGNT;
        end
      end
      ARB_IGNT: begin
        ramREN  = iREN;
        ramaddr = iaddr;
        iload   = ramload;
        iwait   = !icomp;
        if (ramstate == ACCESS || ramstate == ERROR || !iREN) state_d = ARB_IDLE;
      end
      ARB_DGNT: begin
        ramWEN   = dWEN;
        ramREN   = dREN & !dWEN;
        ramaddr  = daddr;
        ramstore = dstore;
        dload    = ramload;
        dwait    = !dcomp;
        if (ramstate == ERROR) begin
          state_d = ARB_IDLE;
        end else if (ramstate == ACCESS) begin
          beat_d = beat_q + BW'(1);
          if (beat_q == BW'(BURST_LEN - 1)) state_d = ARB_IDLE;
        end else if (!dreq) begin
          state_d = ARB_IDLE;
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  always_comb begin
    starve_d = starve_q;
    if (!iREN || icomp)
      starve_d = '0;
    else if (state_q != ARB_IGNT && starve_q != SW'(STARVE_MAX))
      starve_d = starve_q + SW'(1);
  end

`ifdef ARB_PERF_EN
  arb_perf_counter u_iperf (
    .CLK   (CLK),
    .nRST  (nRST),
    .inc_i (icomp),
    .cnt_o (iaccess_cnt)
  );

  arb_perf_counter u_dperf (
    .CLK   (CLK),
    .nRST  (nRST),
    .inc_i (dcomp),
    .cnt_o (daccess_cnt)
  );
`else
  assign iaccess_cnt = '0;
  assign daccess_cnt = '0;
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios plus random traffic checked
// every cycle against a transaction-level ownership model.
module tb_mem_arbiter;
  import cpu_types_pkg::*;

  localparam int BURST_LEN  = 2;
  localparam int STARVE_MAX = 8;

  logic        CLK, nRST;
  logic        iREN, dREN, dWEN;
  word_t       iaddr, daddr, dstore, ramload;
  ramstate_t   ramstate;
  logic        iwait, dwait, ramREN, ramWEN;
  word_t       iload, dload, ramstore, iaccess_cnt, daccess_cnt;
  logic [31:0] ramaddr;

  mem_arbiter #(.BURST_LEN(BURST_LEN), .STARVE_MAX(STARVE_MAX)) dut (
    .CLK(CLK), .nRST(nRST),
    .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
    .dwait(dwait), .dload(dload),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ramstate(ramstate),
    .iaccess_cnt(iaccess_cnt), .daccess_cnt(daccess_cnt)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  int vectors = 0;
  int miscompares = 0;

  // Model: who currently owns the RAM (0 none, 1 icache, 2 dcache), beats
  // finished in the current dcache grant, icache wait age, completion counts.
  int          m_owner, m_beats, m_wait;
  int unsigned m_icnt, m_dcnt;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_owner = 0; m_beats = 0; m_wait = 0; m_icnt = 0; m_dcnt = 0;
  endtask

  task automatic compare_all();
    logic        e_ren, e_wen, e_iw, e_dw;
    logic [31:0] e_addr, e_store, e_il, e_dl, e_ic, e_dc;
    int          own;
    own = nRST ? m_owner : 0;
    e_ren = 0; e_wen = 0; e_iw = 1; e_dw = 1;
    e_addr = 0; e_store = 0; e_il = 0; e_dl = 0;
    if (own == 1) begin
      e_ren = iREN; e_addr = iaddr; e_il = ramload; e_iw = (ramstate != ACCESS);
    end else if (own == 2) begin
      e_wen = dWEN; e_ren = dREN && !dWEN; e_addr = daddr; e_store = dstore;
      e_dl = ramload; e_dw = (ramstate != ACCESS);
    end
`ifdef ARB_PERF_EN
    e_ic = m_icnt; e_dc = m_dcnt;
`else
    e_ic = 0; e_dc = 0;
`endif
    chk("ramREN", ramREN, e_ren);
    chk("ramWEN", ramWEN, e_wen);
    chk("ramaddr", ramaddr, e_addr);
    chk("ramstore", ramstore, e_store);
    chk("iload", iload, e_il);
    chk("dload", dload, e_dl);
    chk("iwait", iwait, e_iw);
    chk("dwait", dwait, e_dw);
    chk("iaccess_cnt", iaccess_cnt, e_ic);
    chk("daccess_cnt", daccess_cnt, e_dc);
  endtask

  task automatic update_model();
    bit icomp, dcomp, dreq;
    int nxt;
    icomp = (m_owner == 1) && (ramstate == ACCESS);
    dcomp = (m_owner == 2) && (ramstate == ACCESS);
    dreq  = dREN || dWEN;
    nxt   = m_owner;
    case (m_owner)
      0: if (dreq && !(iREN && m_wait == STARVE_MAX)) begin nxt = 2; m_beats = 0; end
         else if (iREN) nxt = 1;
      1: if (ramstate == ACCESS || ramstate == ERROR || !iREN) nxt = 0;
      default: begin
        if (ramstate == ERROR) nxt = 0;
        else if (ramstate == ACCESS) begin
          m_beats++;
          if (m_beats == BURST_LEN) nxt = 0;
        end else if (!dreq) nxt = 0;
      end
    endcase
    if (!iREN || icomp) m_wait = 0;
    else if (m_owner != 1 && m_wait < STARVE_MAX) m_wait++;
    if (icomp) m_icnt++;
    if (dcomp) m_dcnt++;
    m_owner = nxt;
  endtask

  task automatic apply(input logic i, input logic [31:0] ia, input logic d, input logic w,
                       input logic [31:0] da, input logic [31:0] ds,
                       input ramstate_t rs, input logic [31:0] rl);
    @(negedge CLK);
    iREN = i; iaddr = ia; dREN = d; dWEN = w; daddr = da; dstore = ds;
    ramstate = rs; ramload = rl;
    #1;
    compare_all();
  endtask

  task automatic adv();
    @(posedge CLK);
    if (nRST) update_model();
  endtask

  initial begin
    int        n;
    bit        tog;
    ramstate_t rs;
    int        r;
    logic [31:0] exp_i, exp_d;

    nRST = 1'b0;
    iREN = 0; dREN = 0; dWEN = 0; iaddr = 0; daddr = 0; dstore = 0;
    ramload = 0; ramstate = FREE;
    model_reset();

    // Reset: idle outputs even with requests pending
    apply(1, 32'h40, 1, 0, 32'h80, 0, ACCESS, 32'h99);
    chk("rst_iwait", iwait, 1);
    chk("rst_dwait", dwait, 1);
    chk("rst_ramREN", ramREN, 0);
    chk("rst_ramaddr", ramaddr, 0);
    adv();
    @(negedge CLK);
    iREN = 0; dREN = 0; ramstate = FREE;
    nRST = 1'b1;
    adv();

    // Simultaneous request, dcache wins, two-beat burst
    apply(1, 32'h400, 1, 0, 32'h100, 0, FREE, 0);
    chk("sim_idle_ramREN", ramREN, 0);
    adv();
    apply(1, 32'h400, 1, 0, 32'h100, 0, ACCESS, 32'h11111111);
    chk("burst0_addr", ramaddr, 32'h100);
    chk("burst0_dwait", dwait, 0);
    chk("burst0_dload", dload, 32'h11111111);
    chk("burst0_iwait", iwait, 1);
    adv();
    apply(1, 32'h400, 1, 0, 32'h104, 0, ACCESS, 32'h22222222);
    chk("burst1_addr", ramaddr, 32'h104);
    chk("burst1_dwait", dwait, 0);
    chk("burst1_dload", dload, 32'h22222222);
    adv();
    apply(1, 32'h400, 0, 0, 32'h104, 0, FREE, 0);
    chk("post_burst_idle", ramREN, 0);
    adv();
    apply(1, 32'h400, 0, 0, 0, 0, ACCESS, 32'hCAFEF00D);
    chk("ifetch_iwait", iwait, 0);
    chk("ifetch_iload", iload, 32'hCAFEF00D);
    adv();

    // Starvation guard: dcache rerequests continuously, BUSY then ACCESS
    n = 0; tog = 0;
    while (m_owner != 1 && n < 40) begin
      if (m_owner == 2) begin rs = tog ? ACCESS : BUSY; tog = !tog; end
      else rs = FREE;
      apply(1, 32'h400, 1, 0, 32'h200, 0, rs, 0);
      adv();
      n++;
    end
    chk("starve_grant_cycles", n, 11);
    apply(1, 32'h400, 1, 0, 32'h200, 0, ACCESS, 32'hDEADBEEF);
    chk("starve_iwait", iwait, 0);
    chk("starve_iload", iload, 32'hDEADBEEF);
    chk("starve_addr", ramaddr, 32'h400);
    adv();

    // ERROR during icache grant, then dcache abort while BUSY
    apply(1, 32'h500, 0, 0, 0, 0, FREE, 0);
    adv();
    apply(1, 32'h500, 0, 0, 0, 0, ERROR, 32'h12345678);
    chk("ierr_iwait", iwait, 1);
    adv();
    apply(0, 32'h500, 0, 0, 0, 0, FREE, 0);
    chk("ierr_idle_addr", ramaddr, 0);
    adv();
    apply(0, 0, 1, 0, 32'h300, 0, FREE, 0);
    adv();
    apply(0, 0, 1, 0, 32'h300, 0, BUSY, 0);
    chk("dbusy_dwait", dwait, 1);
    chk("dbusy_addr", ramaddr, 32'h300);
    adv();
    apply(0, 0, 0, 0, 32'h300, 0, BUSY, 0);
    chk("dabort_dwait", dwait, 1);
    adv();
    apply(0, 0, 0, 0, 32'h300, 0, ACCESS, 32'h55);
    chk("dabort_idle_dwait", dwait, 1);
    chk("dabort_idle_addr", ramaddr, 0);
    adv();

    // Asynchronous reset in the middle of a dcache write
    apply(0, 0, 0, 1, 32'h600, 32'hA5A5A5A5, FREE, 0);
    adv();
    apply(0, 0, 0, 1, 32'h600, 32'hA5A5A5A5, BUSY, 0);
    chk("wr_ramWEN", ramWEN, 1);
    chk("wr_ramstore", ramstore, 32'hA5A5A5A5);
    #2 nRST = 1'b0;
    model_reset();
    #1;
    chk("arst_ramWEN", ramWEN, 0);
    chk("arst_ramREN", ramREN, 0);
    chk("arst_ramaddr", ramaddr, 0);
    adv();
    @(negedge CLK);
    dWEN = 0; ramstate = FREE;
    nRST = 1'b1;
    adv();

    // Completion counters: 3 icache transfers, 4 dcache beats
    for (int k = 0; k < 3; k++) begin
      apply(1, 32'h700 + k, 0, 0, 0, 0, FREE, 0);
      adv();
      apply(1, 32'h700 + k, 0, 0, 0, 0, ACCESS, k);
      adv();
    end
    for (int k = 0; k < 2; k++) begin
      apply(0, 0, 1, 0, 32'h800, 0, FREE, 0);
      adv();
      apply(0, 0, 1, 0, 32'h800, 0, ACCESS, 0);
      adv();
      apply(0, 0, 1, 0, 32'h804, 0, ACCESS, 0);
      adv();
    end
    apply(0, 0, 0, 0, 0, 0, FREE, 0);
`ifdef ARB_PERF_EN
    exp_i = 3; exp_d = 4;
`else
    exp_i = 0; exp_d = 0;
`endif
    chk("perf_icnt", iaccess_cnt, exp_i);
    chk("perf_dcnt", daccess_cnt, exp_d);
    adv();

    // Random traffic
    for (int c = 0; c < 3000; c++) begin
      r = $urandom_range(0, 9);
      if (r < 4)      rs = ACCESS;
      else if (r < 6) rs = BUSY;
      else if (r < 8) rs = FREE;
      else            rs = ERROR;
      apply($urandom_range(0, 9) < 6, $urandom, $urandom_range(0, 9) < 5,
            $urandom_range(0, 3) == 0, $urandom, $urandom, rs, $urandom);
      adv();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
